// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose:
//    Issue side of the adiabatic ALU datapath. Accepts one ALU operation at a
//    time over a valid/ready request handshake. It decodes the operation into
//    the ALU static controls and holds them while the phased pipeline
//    evaluates. It pulses the operand-load and result-load strobes at fixed
//    offsets. It captures the ALU output and zero flag, then returns them over
//    a valid/ready response handshake. Exactly one operation is in flight.
//
// Parameters:
//    EVAL_CYCLES  cycles between operand load strobe and result load strobe (>= 1)
//    OUT_CYCLES   cycles after result load before the output mux is sampled (>= 1)
//    OP_W         width of req_op (>= 3)
//
// Ports:
//    clkpos              sole clock, rising-edge
//    reset               synchronous, active-high reset
//    req_valid/ready     request handshake (ready only while idle)
//    req_op              0=AND 1=OR 2=ADD 3=SUB 4=SLT, others illegal
//    req_asel            -> {B_mux1,B_mux0}  A-operand source select
//    req_bsel            -> A_mux            B-operand source select
//    req_osel            -> {mux3_1,mux3_0}  output mux select
//    ALU_Control1/0      result mux select
//    SUB, STL            conditional-invert enables for A / B operand
//    Adder_Cin           adder carry-in
//    A_Fclkpos           one-cycle operand-register load strobe
//    ALU_O_Fclkpos       one-cycle result-register load strobe
//    out                 ALU final output (sampled at end of last SETTLE cycle)
//    out_Zero_Detect     ALU zero flag (sampled at end of WRITE cycle)
//    rsp_valid/ready     response handshake
//    rsp_data/zero/err   captured result, zero flag, illegal-opcode flag
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int EVAL_CYCLES = 14,
   parameter int OUT_CYCLES  = 2,
   parameter int OP_W        = 4
) (
   input  logic            clkpos,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [OP_W-1:0] req_op,
   input  logic [1:0]      req_asel,
   input  logic            req_bsel,
   input  logic [1:0]      req_osel,
   output logic            ALU_Control0,
   output logic            ALU_Control1,
   output logic            SUB,
   output logic            STL,
   output logic            Adder_Cin,
   output logic            B_mux0,
   output logic            B_mux1,
   output logic            A_mux,
   output logic            mux3_0,
   output logic            mux3_1,
   output logic            A_Fclkpos,
   output logic            ALU_O_Fclkpos,
   input  logic [15:0]     out,
   input  logic            out_Zero_Detect,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [15:0]     rsp_data,
   output logic            rsp_zero,
   output logic            rsp_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_EVAL   = 3'd2,
      S_WRITE  = 3'd3,
      S_SETTLE = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   localparam logic [OP_W-1:0] OP_AND = OP_W'(0);
   localparam logic [OP_W-1:0] OP_OR  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
   localparam logic [OP_W-1:0] OP_SLT = OP_W'(4);

   // One shared down-counter serves both EVAL and SETTLE.
   localparam int CNT_MAX = (EVAL_CYCLES > OUT_CYCLES) ? EVAL_CYCLES : OUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(EVAL_CYCLES - 1);
   localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       ctrl_q;   // {ALU_Control1, ALU_Control0, SUB, STL, Adder_Cin}
   logic [4:0]       sel_q;    // {B_mux1, B_mux0, A_mux, mux3_1, mux3_0}

   assign {ALU_Control1, ALU_Control0, SUB, STL, Adder_Cin} = ctrl_q;
   assign {B_mux1, B_mux0, A_mux, mux3_1, mux3_0}           = sel_q;

   // Static ALU controls for a legal opcode.
   // SUB computes B - A (invert A, carry in 1); SLT computes A + ~B + 1 and
   // selects the replicated carry through the result mux.
   function automatic logic [4:0] decode_op(input logic [OP_W-1:0] op);
      logic [4:0] c;
      c = 5'b00_000;
      case (op)
         OP_AND:  c = 5'b00_000;
         OP_OR:   c = 5'b01_000;
         OP_ADD:  c = 5'b10_000;
         OP_SUB:  c = 5'b10_101;
         OP_SLT:  c = 5'b11_011;
         default: c = 5'b00_000;
      endcase
      return c;
   endfunction

   always_ff @(posedge clkpos) begin
      if (reset) begin
         // NOTE: all state uses non-blocking assignment so every register
         // updates from the pre-edge values, independent of statement order.
         state         <= S_IDLE;
         cnt           <= '0;
         ctrl_q        <= '0;
         sel_q         <= '0;
         req_ready     <= 1'b1;
         A_Fclkpos     <= 1'b0;
         ALU_O_Fclkpos <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_zero      <= 1'b0;
         rsp_err       <= 1'b0;
      end else begin
         // NOTE: strobes default low each cycle, so a single assignment in a
         // transition produces exactly a one-cycle pulse.
         A_Fclkpos     <= 1'b0;
         ALU_O_Fclkpos <= 1'b0;

         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (req_op <= OP_SLT) begin
                     state     <= S_LOAD;
                     A_Fclkpos <= 1'b1;
                     ctrl_q    <= decode_op(req_op);
                     sel_q     <= {req_asel, req_bsel, req_osel};
                     rsp_err   <= 1'b0;
                  end else begin
                     // Illegal opcode: answer immediately, datapath untouched.
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     rsp_zero  <= 1'b0;
                  end
               end
            end

            S_LOAD: begin
               state <= S_EVAL;
               cnt   <= EVAL_LAST;
            end

            S_EVAL: begin
               if (cnt == '0) begin
                  state         <= S_WRITE;
                  ALU_O_Fclkpos <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_WRITE: begin
               rsp_zero <= out_Zero_Detect;
               state    <= S_SETTLE;
               cnt      <= OUT_LAST;
            end

            S_SETTLE: begin
               if (cnt == '0) begin
                  rsp_data  <= out;
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  ctrl_q    <= '0;
                  sel_q     <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end

            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               ctrl_q    <= '0;
               sel_q     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Drives two sequencers: d=0 with default timing (EVAL 14, OUT 2) and d=1
// with EVAL 1, OUT 1. Expected per-cycle behaviour comes from the operation
// timeline relative to the accept cycle T, plus a small opcode table and an
// arithmetic ALU model that supplies the values fed back on out /
// out_Zero_Detect.
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   logic        clkpos = 1'b0;
   logic        reset;
   logic        req_valid_w [2];
   logic [3:0]  req_op;
   logic [1:0]  req_asel;
   logic        req_bsel;
   logic [1:0]  req_osel;
   logic [15:0] out;
   logic        out_Zero_Detect;
   logic        rsp_ready;

   logic        req_ready_w [2];
   logic        c0_w [2], c1_w [2], sub_w [2], stl_w [2], cin_w [2];
   logic        bm0_w [2], bm1_w [2], am_w [2], m30_w [2], m31_w [2];
   logic        astr_w [2], ostr_w [2];
   logic        rsp_valid_w [2], rsp_zero_w [2], rsp_err_w [2];
   logic [15:0] rsp_data_w [2];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clkpos = ~clkpos;

   alu_op_sequencer #(.EVAL_CYCLES(14), .OUT_CYCLES(2), .OP_W(4)) dut0 (
      .clkpos(clkpos), .reset(reset),
      .req_valid(req_valid_w[0]), .req_ready(req_ready_w[0]),
      .req_op(req_op), .req_asel(req_asel), .req_bsel(req_bsel), .req_osel(req_osel),
      .ALU_Control0(c0_w[0]), .ALU_Control1(c1_w[0]), .SUB(sub_w[0]), .STL(stl_w[0]),
      .Adder_Cin(cin_w[0]), .B_mux0(bm0_w[0]), .B_mux1(bm1_w[0]), .A_mux(am_w[0]),
      .mux3_0(m30_w[0]), .mux3_1(m31_w[0]),
      .A_Fclkpos(astr_w[0]), .ALU_O_Fclkpos(ostr_w[0]),
      .out(out), .out_Zero_Detect(out_Zero_Detect),
      .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data_w[0]), .rsp_zero(rsp_zero_w[0]), .rsp_err(rsp_err_w[0])
   );

   alu_op_sequencer #(.EVAL_CYCLES(1), .OUT_CYCLES(1), .OP_W(4)) dut1 (
      .clkpos(clkpos), .reset(reset),
      .req_valid(req_valid_w[1]), .req_ready(req_ready_w[1]),
      .req_op(req_op), .req_asel(req_asel), .req_bsel(req_bsel), .req_osel(req_osel),
      .ALU_Control0(c0_w[1]), .ALU_Control1(c1_w[1]), .SUB(sub_w[1]), .STL(stl_w[1]),
      .Adder_Cin(cin_w[1]), .B_mux0(bm0_w[1]), .B_mux1(bm1_w[1]), .A_mux(am_w[1]),
      .mux3_0(m30_w[1]), .mux3_1(m31_w[1]),
      .A_Fclkpos(astr_w[1]), .ALU_O_Fclkpos(ostr_w[1]),
      .out(out), .out_Zero_Detect(out_Zero_Detect),
      .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data_w[1]), .rsp_zero(rsp_zero_w[1]), .rsp_err(rsp_err_w[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkpos);
      #1;
   endtask

   // Observation helpers for instance d.
   function automatic logic [1:0] hs_of(input int d);
      return {req_ready_w[d], rsp_valid_w[d]};
   endfunction
   function automatic logic [1:0] strobes_of(input int d);
      return {astr_w[d], ostr_w[d]};
   endfunction
   function automatic logic [9:0] static_of(input int d);
      return {c1_w[d], c0_w[d], sub_w[d], stl_w[d], cin_w[d],
              bm1_w[d], bm0_w[d], am_w[d], m31_w[d], m30_w[d]};
   endfunction

   // Opcode table: {ALU_Control1, ALU_Control0, SUB, STL, Adder_Cin}.
   function automatic logic [4:0] ctrl_model(input logic [3:0] op);
      case (op)
         4'd0:    return 5'b00_000;   // AND
         4'd1:    return 5'b01_000;   // OR
         4'd2:    return 5'b10_000;   // ADD
         4'd3:    return 5'b10_101;   // SUB
         4'd4:    return 5'b11_011;   // SLT
         default: return 5'b00_000;
      endcase
   endfunction

   // What the ALU datapath would produce for operands a (A) and b (B).
   function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      logic [16:0] s;
      case (op)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd3: return b - a;
         4'd4: begin
            s = {1'b0, a} + {1'b0, ~b} + 17'd1;
            return {16{s[16]}};
         end
         default: return 16'h0000;
      endcase
   endfunction

   // One complete transaction on instance d, entered in the cycle T where the
   // request is presented. Returns in the cycle after the response handshake.
   // hold = number of RESP cycles with rsp_ready low before it is raised.
   // arm_next raises req_valid during RESP for the following transaction.
   task automatic do_op(input int d, input logic [3:0] op, input logic [1:0] asel,
                        input logic bsel, input logic [1:0] osel, input logic [15:0] res,
                        input int hold, input bit arm_next);
      int          e, o;
      bit          legal;
      logic [9:0]  est;
      logic [15:0] edata;
      logic        ezero;
      e     = (d == 0) ? 14 : 1;
      o     = (d == 0) ? 2 : 1;
      legal = (op < 4'd5);
      est   = {ctrl_model(op), asel, bsel, osel};
      edata = legal ? res : 16'h0000;
      ezero = legal && (res == 16'h0000);

      check("idle_ready", {31'd0, req_ready_w[d]}, 32'd1);
      req_op = op; req_asel = asel; req_bsel = bsel; req_osel = osel;
      req_valid_w[d] = 1'b1;
      out = 16'($urandom); out_Zero_Detect = 1'b0;
      tick();
      req_valid_w[d] = 1'b0;

      if (legal) begin
         // Cycles T+1 .. T+2+e+o: LOAD, EVAL, WRITE, SETTLE.
         for (int k = 1; k <= 2 + e + o; k++) begin
            out             = (k == 2 + e + o) ? res : (res ^ 16'($urandom_range(1, 65535)));
            out_Zero_Detect = (k == 2 + e) ? ezero : ~ezero;
            check("strobes", {30'd0, strobes_of(d)}, {30'd0, (k == 1), (k == 2 + e)});
            check("static", {22'd0, static_of(d)}, {22'd0, est});
            check("busy_hs", {30'd0, hs_of(d)}, 32'd0);
            tick();
         end
      end

      for (int h = 0; h <= hold; h++) begin
         out = 16'($urandom); out_Zero_Detect = ~ezero;
         check("resp_hs", {30'd0, hs_of(d)}, 32'd1);
         check("rsp_data", {16'd0, rsp_data_w[d]}, {16'd0, edata});
         check("rsp_flags", {30'd0, rsp_zero_w[d], rsp_err_w[d]}, {30'd0, ezero, !legal});
         check("resp_quiet", {20'd0, strobes_of(d), static_of(d)}, 32'd0);
         if (arm_next) req_valid_w[d] = 1'b1;
         rsp_ready = (h == hold);
         tick();
      end
      rsp_ready = 1'b0;
   endtask

   // Full post-reset state of instance d.
   task automatic check_reset_state(input int d);
      check("rst_hs", {30'd0, hs_of(d)}, 32'd2);
      check("rst_strobes", {30'd0, strobes_of(d)}, 32'd0);
      check("rst_static", {22'd0, static_of(d)}, 32'd0);
      check("rst_rsp", {15'd0, rsp_data_w[d], rsp_zero_w[d]}, 32'd0);
      check("rst_err", {31'd0, rsp_err_w[d]}, 32'd0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [15:0] a, b;

      reset = 1'b1;
      req_valid_w[0] = 1'b0; req_valid_w[1] = 1'b0;
      req_op = 4'd0; req_asel = 2'd0; req_bsel = 1'b0; req_osel = 2'd0;
      out = 16'h0000; out_Zero_Detect = 1'b0; rsp_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      check_reset_state(0);
      check_reset_state(1);

      // ADD with a fixed ALU answer of 0x1234.
      do_op(0, 4'd2, 2'd0, 1'b1, 2'd1, 16'h1234, 0, 1'b0);
      // SUB producing zero.
      do_op(0, 4'd3, 2'd2, 1'b0, 2'd3, 16'h0000, 0, 1'b0);
      // Illegal opcode.
      do_op(0, 4'd7, 2'd1, 1'b1, 2'd2, 16'hBEEF, 0, 1'b0);
      // Response stalled 5 cycles while the next request waits.
      do_op(0, 4'd4, 2'd3, 1'b1, 2'd0, alu_model(4'd4, 16'h0003, 16'h0009), 5, 1'b1);
      do_op(0, 4'd1, 2'd1, 1'b0, 2'd1, alu_model(4'd1, 16'hA0A0, 16'h0505), 0, 1'b0);

      // Reset in the middle of EVAL: operation abandoned.
      req_op = 4'd2; req_asel = 2'd1; req_bsel = 1'b1; req_osel = 2'd2;
      req_valid_w[0] = 1'b1;
      tick();
      req_valid_w[0] = 1'b0;
      for (int k = 1; k < 8; k++) begin
         check("pre_rst_strobes", {30'd0, strobes_of(0)}, {30'd0, (k == 1), 1'b0});
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_state(0);
      for (int k = 0; k < 20; k++) begin
         out_Zero_Detect = 1'b1;
         check("post_rst_quiet", {28'd0, hs_of(0), strobes_of(0)}, 32'h8);
         tick();
      end

      // Reset coinciding with a handshake: nothing accepted.
      req_op = 4'd2; req_valid_w[0] = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; req_valid_w[0] = 1'b0;
      check_reset_state(0);
      for (int k = 0; k < 20; k++) begin
         check("rst_hs_quiet", {28'd0, hs_of(0), strobes_of(0)}, 32'h8);
         tick();
      end

      // Randomized transactions on the default build.
      for (int i = 0; i < 30; i++) begin
         op = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
         a  = 16'($urandom);
         b  = 16'($urandom);
         if ($urandom_range(0, 4) == 0) b = a;   // exercise zero results
         do_op(0, op, 2'($urandom), 1'($urandom), 2'($urandom), alu_model(op, a, b),
               $urandom_range(0, 3), (i < 29) && ($urandom_range(0, 1) == 1));
      end

      // Short-timing build.
      do_op(1, 4'd2, 2'd0, 1'b1, 2'd1, 16'h1234, 0, 1'b0);
      do_op(1, 4'd9, 2'd3, 1'b0, 2'd0, 16'h5555, 1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         op = 4'($urandom_range(0, 5));
         a  = 16'($urandom);
         b  = 16'($urandom);
         do_op(1, op, 2'($urandom), 1'($urandom), 2'($urandom), alu_model(op, a, b),
               $urandom_range(0, 2), (i < 7) && ($urandom_range(0, 1) == 1));
      end
      check("final_idle0", {30'd0, hs_of(0)}, 32'd2);
      check("final_idle1", {30'd0, hs_of(1)}, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
